// File: rtl/svm_dot_ctrl.sv
// Linear-SVM dot-product sequencer: streams VEC_LEN feature/weight pairs, accumulates, adds bias.
// Optional build macro SVM_SAT_EN: saturating accumulate and bias add (default: wrap-around).
module svm_dot_ctrl #(
   parameter int VEC_LEN = 3780,
   parameter int ADDR_W  = 12,
   parameter int FEAT_W  = 16,
   parameter int WGT_W   = 16,
   parameter int ACC_W   = 40,
   parameter int RD_LAT  = 2
) (
   input  logic              iClk,
   input  logic              iRst_n,
   input  logic              iStart,
   output logic              oBusy,
   output logic [ADDR_W-1:0] oADDR,
   output logic              oRdEn,
   input  logic [FEAT_W-1:0] iFeat,
   input  logic [WGT_W-1:0]  iWgt,
   input  logic [ACC_W-1:0]  iBias,
   output logic [ACC_W-1:0]  oScore,
   output logic              oHuman,
   output logic              oDone
);

   localparam int PROD_W = FEAT_W + WGT_W;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(VEC_LEN - 1);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_BIAS, S_DONE} state_t;

   state_t              state_q;
   logic [ADDR_W-1:0]   addr_q;
   logic                rd_en_q;
   logic                busy_q;
   logic                done_q;
   logic                human_q;
   logic [ACC_W-1:0]    score_q;
   logic [ACC_W-1:0]    acc_q;
   logic [ACC_W-1:0]    bias_q;
   logic [RD_LAT-1:0]   vld_q;
   logic                prod_vld_q;
   logic [PROD_W-1:0]   prod_q;

   logic [PROD_W-1:0]   prod_d;
   logic [ACC_W-1:0]    acc_d;
   logic [ACC_W-1:0]    score_d;

   function automatic logic [ACC_W-1:0] add_acc(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
      logic [ACC_W-1:0] sum;
      sum = a + b;
`ifdef SVM_SAT_EN
      // Equal operand signs with a flipped result sign is overflow: clamp toward the operand sign.
      if ((a[ACC_W-1] == b[ACC_W-1]) && (sum[ACC_W-1] != a[ACC_W-1]))
         sum = a[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
`endif
      return sum;
   endfunction

   assign prod_d  = $signed({{WGT_W{iFeat[FEAT_W-1]}}, iFeat}) * $signed({{FEAT_W{iWgt[WGT_W-1]}}, iWgt});
   assign acc_d   = add_acc(acc_q, {{(ACC_W-PROD_W){prod_q[PROD_W-1]}}, prod_q});
   assign score_d = add_acc(acc_q, bias_q);

   // NOTE: every register here uses <= so all updates see pre-edge values; reset is synchronous.
   always_ff @(posedge iClk) begin
      if (!iRst_n) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         rd_en_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         human_q    <= 1'b0;
         score_q    <= '0;
         acc_q      <= '0;
         bias_q     <= '0;
         vld_q      <= '0;
         prod_vld_q <= 1'b0;
         prod_q     <= '0;
      end else begin
         // Read-valid pipe mirrors the memory latency so only returned pairs reach the MAC.
         vld_q      <= (vld_q << 1) | RD_LAT'(rd_en_q);
         prod_vld_q <= vld_q[RD_LAT-1];
         if (vld_q[RD_LAT-1]) prod_q <= prod_d;
         if (prod_vld_q)      acc_q  <= acc_d;
         done_q <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (iStart) begin
                  state_q <= S_ISSUE;
                  busy_q  <= 1'b1;
                  rd_en_q <= 1'b1;
                  addr_q  <= '0;
                  acc_q   <= '0;
                  bias_q  <= iBias;
               end
            end
            S_ISSUE: begin
               if (addr_q == LAST_ADDR) begin
                  state_q <= S_DRAIN;
                  rd_en_q <= 1'b0;
               end else begin
                  addr_q <= addr_q + ADDR_W'(1);
               end
            end
            S_DRAIN: begin
               if ((vld_q == '0) && !prod_vld_q) state_q <= S_BIAS;
            end
            S_BIAS: begin
               score_q <= score_d;
               human_q <= ~score_d[ACC_W-1] & (|score_d);
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_DONE;
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign oBusy  = busy_q;
   assign oADDR  = addr_q;
   assign oRdEn  = rd_en_q;
   assign oScore = score_q;
   assign oHuman = human_q;
   assign oDone  = done_q;

endmodule
